// File: rtl/div_pkg.sv
// Shared definitions for the pipelined divider.
// Holds the configuration legality check used at elaboration.
package div_pkg;

  // Each stage resolves WIDTH/STAGES quotient bits, so the split must be exact.
  function automatic bit cfg_ok(int width, int stages);
    return (width >= 2) && (stages >= 1)
        && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/div_iter_stage.sv
// Combinational block of B restoring-division steps, MSB first.
// Ports: rem/quo/dvd/dvs/start in, rem_next/quo_next out.
module div_iter_stage
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int B     = 4
) (
  input  logic [WIDTH:0]           rem,
  input  logic [WIDTH-1:0]         quo,
  input  logic [WIDTH-1:0]         dvd,
  input  logic [WIDTH-1:0]         dvs,
  input  logic [$clog2(WIDTH)-1:0] start,
  output logic [WIDTH:0]           rem_next,
  output logic [WIDTH-1:0]         quo_next
);

  localparam int IW = $clog2(WIDTH);

  logic [WIDTH:0]    r;
  logic [WIDTH-1:0]  q;
  logic [IW-1:0]     idx;

  // idx wraps below zero after the final step; that value is never used.
  always_comb begin
    r   = rem;
    q   = quo;
    idx = start;
    for (int j = 0; j < B; j++) begin
      r = {r[WIDTH-1:0], dvd[idx]};
      if (r >= {1'b0, dvs}) begin
        r      = r - {1'b0, dvs};
        q[idx] = 1'b1;
      end
      idx = idx - IW'(1);
    end
  end

  assign rem_next = r;
  assign quo_next = q;

endmodule

// File: rtl/div_pipe_valrdy.sv
// Fully pipelined signed/unsigned divider with valid/ready on both sides.
// Ports: in_* op + tag, out_* quotient/remainder/dbz/tag, clk, reset.
module div_pipe_valrdy
  import div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 8,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int B  = WIDTH / STAGES;
  localparam int IW = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic             dbz;
    logic [WIDTH-1:0] orig;
    logic [TAG_W-1:0] tag;
    logic             valid;
  } stage_t;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("div_pipe_valrdy: WIDTH must be a multiple of STAGES");
  end

  stage_t prep;
  stage_t fin;
  stage_t res;
  logic   adv;
  logic   a_neg;
  logic   b_neg;

  assign adv      = !res.valid || out_ready;
  assign in_ready = adv;

  // Magnitudes are formed at entry; -MIN wraps to MIN, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  always_comb begin
    prep  = '0;
    a_neg = in_signed & in_dividend[WIDTH-1];
    b_neg = in_signed & in_divisor[WIDTH-1];
    if (in_valid) begin
      prep.valid = 1'b1;
      prep.dvd   = a_neg ? -in_dividend : in_dividend;
      prep.dvs   = b_neg ? -in_divisor : in_divisor;
      prep.neg_q = a_neg ^ b_neg;
      prep.neg_r = a_neg;
      prep.dbz   = (in_divisor == '0);
      prep.orig  = in_dividend;
      prep.tag   = in_tag;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    stage_t           src;
    stage_t           cur;
    stage_t           nxt;
    logic [WIDTH:0]   r_n;
    logic [WIDTH-1:0] q_n;

    if (k == 0) begin : g_in
      assign src = prep;
    end else begin : g_mid
      assign src = g_st[k-1].nxt;
    end

    // Bubbles only clear the valid bit; payload holds.
    always_ff @(posedge clk) begin
      if (reset) begin
        cur <= '0;
      end else if (adv) begin
        if (src.valid) cur <= src;
        else           cur.valid <= 1'b0;
      end
    end

    div_iter_stage #(
      .WIDTH (WIDTH),
      .B     (B)
    ) u_iter (
      .rem      (cur.rem),
      .quo      (cur.quo),
      .dvd      (cur.dvd),
      .dvs      (cur.dvs),
      .start    (IW'(WIDTH - 1 - k * B)),
      .rem_next (r_n),
      .quo_next (q_n)
    );

    // Sign fix-up and the divide-by-zero override live in the last stage.
    always_comb begin
      nxt     = cur;
      nxt.rem = r_n;
      nxt.quo = q_n;
      if (k == STAGES - 1) begin
        if (cur.dbz) begin
          nxt.quo = '1;
          nxt.rem = {1'b0, cur.orig};
        end else begin
          if (cur.neg_q) nxt.quo = -q_n;
          if (cur.neg_r) nxt.rem = {1'b0, -r_n[WIDTH-1:0]};
        end
      end
    end
  end

  assign fin = g_st[STAGES-1].nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      res <= '0;
    end else if (adv) begin
      if (fin.valid) res <= fin;
      else           res.valid <= 1'b0;
    end
  end

  assign out_valid       = res.valid;
  assign out_quotient    = res.quo;
  assign out_remainder   = res.rem[WIDTH-1:0];
  assign out_div_by_zero = res.dbz;
  assign out_tag         = res.tag;

  logic unused_res;
  assign unused_res = ^{res.rem[WIDTH], res.dvd, res.dvs,
                        res.neg_q, res.neg_r, res.orig};

endmodule

// File: tb/tb_div_pipe_valrdy.sv
// Directed and soak bench for div_pipe_valrdy.
// Drives/samples on the falling edge; DUT updates on the rising edge.
module tb_div_pipe_valrdy;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [31:0] in_dividend, in_divisor, out_quotient, out_remainder;
  logic        out_div_by_zero;
  logic [3:0]  in_tag, out_tag;

  logic        in_valid16, in_ready16, in_signed16;
  logic        out_valid16, out_ready16, out_dbz16;
  logic [15:0] in_dividend16, in_divisor16, out_q16, out_r16;
  logic [3:0]  in_tag16, out_tag16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_pipe_valrdy #(.WIDTH(32), .STAGES(8), .TAG_W(4)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_div_by_zero(out_div_by_zero), .out_tag(out_tag)
  );

  div_pipe_valrdy #(.WIDTH(16), .STAGES(4), .TAG_W(4)) u_dut16 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .in_dividend(in_dividend16), .in_divisor(in_divisor16),
    .in_signed(in_signed16), .in_tag(in_tag16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_quotient(out_q16), .out_remainder(out_r16),
    .out_div_by_zero(out_dbz16), .out_tag(out_tag16)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    logic [3:0]  t;
  } res_t;

  // Behavioural reference built on the language's own / and %.
  function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input logic [3:0] t);
    res_t o;
    o.t = t;
    o.z = 1'b0;
    if (b == 32'd0) begin
      o.q = 32'hFFFF_FFFF;
      o.r = a;
      o.z = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      o.q = 32'h8000_0000;
      o.r = 32'd0;
    end else if (s) begin
      o.q = 32'($signed(a) / $signed(b));
      o.r = 32'($signed(a) % $signed(b));
    end else begin
      o.q = a / b;
      o.r = a % b;
    end
    return o;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [3:0] t,
                        output res_t o, output int lat);
    @(negedge clk);
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    in_signed   = s;
    in_tag      = t;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) break;
      lat++;
    end
    o.q = out_quotient;
    o.r = out_remainder;
    o.z = out_div_by_zero;
    o.t = out_tag;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    in_dividend = '0;
    in_divisor  = '0;
    in_signed   = 1'b0;
    in_tag      = '0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", out_valid);
    end
    if (out_quotient !== 32'd0) begin
      errors++; $display("FAIL reset_q got %h want 0", out_quotient);
    end
    if (out_remainder !== 32'd0) begin
      errors++; $display("FAIL reset_r got %h want 0", out_remainder);
    end
    if (out_div_by_zero !== 1'b0) begin
      errors++; $display("FAIL reset_dbz got %b want 0", out_div_by_zero);
    end
    if (out_tag !== 4'd0) begin
      errors++; $display("FAIL reset_tag got %h want 0", out_tag);
    end
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    res_t o;
    int   lat;
    run_op(32'd100, 32'd7, 1'b0, 4'd9, o, lat);
    checks += 5;
    if (lat !== 8) begin
      errors++; $display("FAIL u_latency got %0d want 8", lat);
    end
    if (o.q !== 32'd14) begin
      errors++; $display("FAIL u_q got %h want e", o.q);
    end
    if (o.r !== 32'd2) begin
      errors++; $display("FAIL u_r got %h want 2", o.r);
    end
    if (o.z !== 1'b0) begin
      errors++; $display("FAIL u_dbz got %b want 0", o.z);
    end
    if (o.t !== 4'd9) begin
      errors++; $display("FAIL u_tag got %h want 9", o.t);
    end
  endtask

  task automatic test_signed();
    res_t o;
    int   lat;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 4'd1, o, lat);
    checks += 2;
    if (o.q !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL s_m7d2_q got %h want fffffffd", o.q);
    end
    if (o.r !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL s_m7d2_r got %h want ffffffff", o.r);
    end
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 4'd2, o, lat);
    checks += 2;
    if (o.q !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL s_7dm2_q got %h want fffffffd", o.q);
    end
    if (o.r !== 32'd1) begin
      errors++; $display("FAIL s_7dm2_r got %h want 1", o.r);
    end
  endtask

  task automatic test_div_zero();
    res_t o;
    int   lat;
    for (int m = 0; m < 2; m++) begin
      run_op(32'd5, 32'd0, m[0], 4'd3, o, lat);
      checks += 3;
      if (o.q !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL dbz%0d_q got %h want ffffffff", m, o.q);
      end
      if (o.r !== 32'd5) begin
        errors++; $display("FAIL dbz%0d_r got %h want 5", m, o.r);
      end
      if (o.z !== 1'b1) begin
        errors++; $display("FAIL dbz%0d_flag got %b want 1", m, o.z);
      end
    end
  endtask

  task automatic test_overflow();
    res_t o;
    int   lat;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'd4, o, lat);
    checks += 3;
    if (o.q !== 32'h8000_0000) begin
      errors++; $display("FAIL ovf_q got %h want 80000000", o.q);
    end
    if (o.r !== 32'd0) begin
      errors++; $display("FAIL ovf_r got %h want 0", o.r);
    end
    if (o.z !== 1'b0) begin
      errors++; $display("FAIL ovf_dbz got %b want 0", o.z);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [12];
    logic [31:0] vb [12];
    logic        vs [12];
    logic [31:0] eq [12];
    logic [31:0] er [12];
    logic        ez [12];
    int          in_idx, out_idx;
    logic        hold;
    logic [31:0] sq, sr;
    logic        sz;
    logic [3:0]  st;
    va[0]  = 32'd1000;       vb[0]  = 32'd10;         vs[0]  = 0;
    eq[0]  = 32'd100;        er[0]  = 32'd0;          ez[0]  = 0;
    va[1]  = 32'd255;        vb[1]  = 32'd16;         vs[1]  = 0;
    eq[1]  = 32'd15;         er[1]  = 32'd15;         ez[1]  = 0;
    va[2]  = 32'hFFFF_FF9C;  vb[2]  = 32'd7;          vs[2]  = 1;
    eq[2]  = 32'hFFFF_FFF2;  er[2]  = 32'hFFFF_FFFE;  ez[2]  = 0;
    va[3]  = 32'hFFFF_FFFF;  vb[3]  = 32'd2;          vs[3]  = 0;
    eq[3]  = 32'h7FFF_FFFF;  er[3]  = 32'd1;          ez[3]  = 0;
    va[4]  = 32'hFFFF_FFFF;  vb[4]  = 32'd2;          vs[4]  = 1;
    eq[4]  = 32'd0;          er[4]  = 32'hFFFF_FFFF;  ez[4]  = 0;
    va[5]  = 32'd9;          vb[5]  = 32'd0;          vs[5]  = 1;
    eq[5]  = 32'hFFFF_FFFF;  er[5]  = 32'd9;          ez[5]  = 1;
    va[6]  = 32'd123456;     vb[6]  = 32'd1000;       vs[6]  = 0;
    eq[6]  = 32'd123;        er[6]  = 32'd456;        ez[6]  = 0;
    va[7]  = 32'd50;         vb[7]  = 32'hFFFF_FFFB;  vs[7]  = 1;
    eq[7]  = 32'hFFFF_FFF6;  er[7]  = 32'd0;          ez[7]  = 0;
    va[8]  = 32'h8000_0000;  vb[8]  = 32'hFFFF_FFFF;  vs[8]  = 0;
    eq[8]  = 32'd0;          er[8]  = 32'h8000_0000;  ez[8]  = 0;
    va[9]  = 32'd3;          vb[9]  = 32'd5;          vs[9]  = 0;
    eq[9]  = 32'd0;          er[9]  = 32'd3;          ez[9]  = 0;
    va[10] = 32'hFFFF_FFF7;  vb[10] = 32'hFFFF_FFFC;  vs[10] = 1;
    eq[10] = 32'd2;          er[10] = 32'hFFFF_FFFF;  ez[10] = 0;
    va[11] = 32'hDEAD_BEEF;  vb[11] = 32'h0001_0000;  vs[11] = 0;
    eq[11] = 32'h0000_DEAD;  er[11] = 32'h0000_BEEF;  ez[11] = 0;
    in_idx  = 0;
    out_idx = 0;
    hold    = 1'b0;
    sq = '0; sr = '0; sz = 1'b0; st = '0;
    for (int c = 0; c < 100 && out_idx < 12; c++) begin
      @(negedge clk);
      out_ready = !(c >= 10 && c <= 12);
      if (in_idx < 12) begin
        in_valid    = 1'b1;
        in_dividend = va[in_idx];
        in_divisor  = vb[in_idx];
        in_signed   = vs[in_idx];
        in_tag      = 4'(in_idx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready && out_valid) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_stall_in_ready c%0d got %b want 0", c, in_ready);
        end
      end
      if (hold) begin
        checks++;
        if ({out_valid, out_quotient, out_remainder, out_div_by_zero, out_tag}
            !== {1'b1, sq, sr, sz, st}) begin
          errors++;
          $display("FAIL b2b_hold c%0d got %h/%h/%b/%h want %h/%h/%b/%h",
                   c, out_quotient, out_remainder, out_div_by_zero, out_tag,
                   sq, sr, sz, st);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if ({out_quotient, out_remainder, out_div_by_zero, out_tag} !==
            {eq[out_idx], er[out_idx], ez[out_idx], 4'(out_idx)}) begin
          errors++;
          $display("FAIL b2b_result%0d got %h/%h/%b/tag%h want %h/%h/%b/tag%h",
                   out_idx, out_quotient, out_remainder, out_div_by_zero,
                   out_tag, eq[out_idx], er[out_idx], ez[out_idx], out_idx);
        end
        out_idx++;
      end
      hold = out_valid && !out_ready;
      sq = out_quotient; sr = out_remainder;
      sz = out_div_by_zero; st = out_tag;
      if (in_valid && in_ready) in_idx++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_idx != 12) begin
      errors++; $display("FAIL b2b_count got %0d want 12", out_idx);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_extra got valid %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_flight();
    res_t o;
    int   lat;
    int   stale;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      in_dividend = 32'd1000 + 32'(i);
      in_divisor  = 32'd3;
      in_signed   = 1'b0;
      in_tag      = 4'(i + 5);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rstfl_valid got %b want 0", out_valid);
    end
    if ({out_quotient, out_remainder, out_div_by_zero, out_tag} !== 69'd0) begin
      errors++;
      $display("FAIL rstfl_zero got %h/%h/%b/%h want all 0",
               out_quotient, out_remainder, out_div_by_zero, out_tag);
    end
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL rstfl_stale got %0d valid cycles want 0", stale);
    end
    run_op(32'd77, 32'd7, 1'b0, 4'd6, o, lat);
    checks += 3;
    if (lat !== 8) begin
      errors++; $display("FAIL rstfl_latency got %0d want 8", lat);
    end
    if (o.q !== 32'd11 || o.r !== 32'd0) begin
      errors++; $display("FAIL rstfl_result got %h/%h want b/0", o.q, o.r);
    end
    if (o.t !== 4'd6) begin
      errors++; $display("FAIL rstfl_tag got %h want 6", o.t);
    end
  endtask

  task automatic test_w16();
    int lat;
    in_valid16  = 1'b1;
    out_ready16 = 1'b1;
    in_dividend16 = 16'hFFFF;
    in_divisor16  = 16'h0001;
    in_signed16   = 1'b0;
    in_tag16      = 4'hA;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_valid16 = 1'b0;
      if (out_valid16) break;
      lat++;
    end
    checks += 3;
    if (lat !== 4) begin
      errors++; $display("FAIL w16_latency got %0d want 4", lat);
    end
    if (out_q16 !== 16'hFFFF || out_r16 !== 16'h0000) begin
      errors++; $display("FAIL w16_result got %h/%h want ffff/0", out_q16, out_r16);
    end
    if (out_tag16 !== 4'hA || out_dbz16 !== 1'b0) begin
      errors++; $display("FAIL w16_tag got %h/%b want a/0", out_tag16, out_dbz16);
    end
  endtask

  task automatic test_soak();
    res_t        sb [$];
    res_t        e;
    int          sent, got;
    logic        acc, hold;
    logic [31:0] a, b;
    logic [31:0] sq, sr;
    logic        sz;
    logic [3:0]  st;
    localparam int N = 10000;
    sent = 0; got = 0; acc = 1'b0; hold = 1'b0;
    sq = '0; sr = '0; sz = 1'b0; st = '0;
    in_valid = 1'b0;
    for (int c = 0; c < 60000 && got < N; c++) begin
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      if (!in_valid && sent < N && $urandom_range(0, 3) != 0) begin
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 7))
          0: b = 32'd0;
          1: b = 32'($signed($urandom_range(0, 16)) - 8);
          2: b = a >> $urandom_range(0, 31);
          3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
          4: a = 32'($signed($urandom_range(0, 200)) - 100);
          default: ;
        endcase
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        in_signed   = $urandom_range(0, 1) == 1;
        in_tag      = 4'(sent);
      end
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (hold) begin
        checks++;
        if ({out_valid, out_quotient, out_remainder, out_div_by_zero, out_tag}
            !== {1'b1, sq, sr, sz, st}) begin
          errors++; $display("FAIL soak_hold c%0d output changed while stalled", c);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL soak_extra c%0d got result with empty scoreboard", c);
        end else begin
          e = sb.pop_front();
          if ({out_quotient, out_remainder, out_div_by_zero, out_tag} !==
              {e.q, e.r, e.z, e.t}) begin
            errors++;
            $display("FAIL soak_result%0d got %h/%h/%b/%h want %h/%h/%b/%h",
                     got, out_quotient, out_remainder, out_div_by_zero,
                     out_tag, e.q, e.r, e.z, e.t);
          end
        end
        got++;
      end
      hold = out_valid && !out_ready;
      sq = out_quotient; sr = out_remainder;
      sz = out_div_by_zero; st = out_tag;
      acc = in_valid && in_ready;
      if (acc) begin
        sb.push_back(ref_div(in_dividend, in_divisor, in_signed, in_tag));
        sent++;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != N || sb.size() != 0) begin
      errors++; $display("FAIL soak_count got %0d left %0d want %0d left 0", got, sb.size(), N);
    end
  endtask

  initial begin
    in_valid16    = 1'b0;
    out_ready16   = 1'b1;
    in_dividend16 = '0;
    in_divisor16  = '0;
    in_signed16   = 1'b0;
    in_tag16      = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_flight();
    test_w16();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
